div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 35 +++
 rtl/div_unit.sv | 160 ++++++++++++++++
 tb/tb_div_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the RV32M divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int XLEN     = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // Magnitude of an operand; unsigned operands pass through untouched.
    function automatic logic [XLEN-1:0] op_mag(input logic [XLEN-1:0] v,
                                               input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative 32-bit radix-2 restoring divider (DIV/DIVU/REM/REMU).
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_in1,
    input  logic [XLEN-1:0] div_in2,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_out
);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    div_op_e          r_op;
    logic [XLEN:0]    r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_dvsr;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [XLEN-1:0]  r_result;

    logic             w_signed;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [XLEN-1:0]  w_special_res;
    logic [XLEN+1:0]  w_shift;
    logic [XLEN+1:0]  w_diff;
    logic             w_ge;
    logic [XLEN:0]    w_rem_nxt;
    logic [XLEN-1:0]  w_quo_nxt;
    logic [XLEN-1:0]  w_quo_fix;
    logic [XLEN-1:0]  w_rem_fix;
    logic [XLEN-1:0]  w_calc_res;
    logic             w_unused;

    // ------------------------------------------------------------------
    // Special-case detection on the raw request operands
    // ------------------------------------------------------------------
    assign w_signed   = ~div_op[0];
    assign w_div_zero = (div_in2 == '0);
    assign w_ovf      = w_signed && (div_in1 == {1'b1, {(XLEN-1){1'b0}}})
                                 && (div_in2 == '1);
    assign w_special  = w_div_zero | w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = div_op[1] ? div_in1 : '1;
        end else begin
            w_special_res = div_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // One restoring step: dividend bits shift out of r_quo into the
    // partial remainder while quotient bits shift in from the bottom.
    // ------------------------------------------------------------------
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {2'b00, r_dvsr};
    assign w_ge      = ~w_diff[XLEN+1];
    assign w_rem_nxt = w_ge ? w_diff[XLEN:0] : w_shift[XLEN:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

    // The remainder never reaches 2^32, so the shifted-out MSB is always zero.
    assign w_unused  = r_rem[XLEN];

    // Sign correction is folded into the final step so the result lands
    // in r_result on the very edge that enters DONE.
    assign w_quo_fix  = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix  = r_neg_r ? -w_rem_nxt[XLEN-1:0] : w_rem_nxt[XLEN-1:0];
    assign w_calc_res = ((r_op == REM) || (r_op == REMU)) ? w_rem_fix : w_quo_fix;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (div_start) begin
                    w_state_nxt = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= DIV;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (div_start) begin
                        r_op    <= div_op_e'(div_op);
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= op_mag(div_in1, w_signed);
                        r_dvsr  <= op_mag(div_in2, w_signed);
                        r_neg_q <= w_signed & (div_in1[XLEN-1] ^ div_in2[XLEN-1]);
                        r_neg_r <= w_signed & div_in1[XLEN-1];
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_result <= w_calc_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_busy = (r_state != IDLE);
    assign div_done = (r_state == DONE);
    assign div_out  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] div_in1;
    logic [31:0] div_in2;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_out;

    int total = 0;
    int bad   = 0;

    div_unit u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_start (div_start),
        .div_op    (div_op),
        .div_in1   (div_in1),
        .div_in2   (div_in2),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .div_out   (div_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request and follows it to completion. A non-zero dup_at
    // drives a second request in that cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat,
                          input int dup_at);
        int cyc;
        int busy_err;
        @(negedge clk);
        div_op    = op;
        div_in1   = a;
        div_in2   = b;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        cyc       = 1;
        busy_err  = 0;
        while (cyc <= 40) begin
            if (div_busy !== 1'b1) busy_err++;
            if (cyc == dup_at) begin
                div_op    = DIVU;
                div_in1   = 32'd1000;
                div_in2   = 32'd3;
                div_start = 1'b1;
            end
            if (div_done === 1'b1) break;
            @(posedge clk);
            #1;
            div_start = 1'b0;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, div_out, exp);
        check({tag, " busy_gaps"}, 32'(busy_err), 32'd0);
        @(posedge clk);
        #1;
        div_start = 1'b0;
        check({tag, " done_pulse"}, {31'd0, div_done}, 32'd0);
        check({tag, " idle_after"}, {31'd0, div_busy}, 32'd0);
        check({tag, " held"}, div_out, exp);
    endtask

    initial begin
        int cyc;
        int done_seen;
        rst_n     = 1'b0;
        div_start = 1'b0;
        div_op    = 2'b00;
        div_in1   = '0;
        div_in2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, div_busy}, 32'd0);
        check("reset done", {31'd0, div_done}, 32'd0);
        check("reset out", div_out, 32'd0);
        rst_n = 1'b1;

        run_op("divu_100_7",      DIVU, 32'd100,       32'd7,         32'd14,        33, 0);
        run_op("divu_dup",        DIVU, 32'd100,       32'd7,         32'd14,        33, 5);
        run_op("div_m7_2",        DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
        run_op("rem_m7_2",        REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
        run_op("remu_max_16",     REMU, 32'hFFFF_FFFF, 32'd16,        32'd15,        33, 0);
        run_op("div_7_m2",        DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
        run_op("rem_7_m2",        REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33, 0);
        run_op("div_min_1",       DIV,  32'h8000_0000, 32'd1,         32'h8000_0000, 33, 0);
        run_op("divu_max_1",      DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 0);
        run_op("divu_min_max",    DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 0);
        run_op("divu_5_0",        DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1);
        run_op("remu_5_0",        REMU, 32'd5,         32'd0,         32'd5,         1,  0);
        run_op("div_m5_0",        DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1,  0);
        run_op("rem_m5_0",        REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1,  0);
        run_op("div_ovf",         DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
        run_op("rem_ovf",         REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);
        run_op("remu_big_dvsr",   REMU, 32'h1234_5678, 32'h8000_0000, 32'h1234_5678, 33, 0);

        // Abort a DIVU mid-flight with reset.
        @(negedge clk);
        div_op    = DIVU;
        div_in1   = 32'd1000;
        div_in2   = 32'd3;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        cyc       = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", {31'd0, div_busy}, 32'd0);
        check("abort done", {31'd0, div_done}, 32'd0);
        check("abort out", div_out, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (div_done === 1'b1 || div_busy === 1'b1) done_seen++;
        end
        check("abort no_done", 32'(done_seen), 32'd0);
        run_op("divu_after_rst", DIVU, 32'd1000, 32'd3, 32'd333, 33, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
